// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline requester and memory-macro signals for mem_port_arbiter.
//   slave  : arbiter view (requests and mem_rdata in; grants, read data and memory controls out)
//   master : view of whatever drives the requests and models the memory
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [15:0]       if_rdata;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [15:0]       ld_rdata;

    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [15:0]       st_data;
    logic              st_gnt;
    logic              st_done;

    logic [ADDR_W-2:0] mem_addr;
    logic              mem_ren;
    logic [15:0]       mem_rdata;
    logic              mem_wen;
    logic [1:0]        mem_wbe;
    logic [15:0]       mem_wdata;

    modport slave (
        input  if_req, if_addr, ld_req, ld_addr, st_req, st_addr, st_data, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata, st_gnt, st_done,
               mem_addr, mem_ren, mem_wen, mem_wbe, mem_wdata
    );

    modport master (
        output if_req, if_addr, ld_req, ld_addr, st_req, st_addr, st_data, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata, st_gnt, st_done,
               mem_addr, mem_ren, mem_wen, mem_wbe, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported 16-bit word memory between instruction fetch, data load
// and data store. Byte addresses; odd addresses are split into two word accesses.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (requester handshakes + memory macro controls)
// Grants and memory controls are combinational in the grant cycle; rvalid is registered.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned WORD_W = ADDR_W - 1;
    localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, LD_HI, ST_HI} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [WORD_W-1:0] widx_q, widx_d;     // first word index of a split access
    logic [7:0]        byte_q, byte_d;     // carried byte: load low byte or store high byte
    logic              rd_ld_q, rd_ld_d;   // split read belongs to the load port
    logic              if_rv_q, if_rv_d;
    logic              ld_rv_q, ld_rv_d;
    logic              mis_q, mis_d;       // pending rvalid is the tail of a split read

    logic              promote;
    logic              rd_go;
    logic [ADDR_W-1:0] rd_addr;

    assign promote = (starve_q == CNT_W'(STARVE_LIMIT));

    // Arbitration, memory access issue and next-state; everything is held at zero in reset
    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        widx_d        = widx_q;
        byte_d        = byte_q;
        rd_ld_d       = rd_ld_q;
        if_rv_d       = 1'b0;
        ld_rv_d       = 1'b0;
        mis_d         = 1'b0;
        rd_go         = 1'b0;
        rd_addr       = '0;
        bus.if_gnt    = 1'b0;
        bus.ld_gnt    = 1'b0;
        bus.st_gnt    = 1'b0;
        bus.st_done   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_ren   = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_wbe   = 2'b00;
        bus.mem_wdata = 16'h0000;

        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    // Starved fetch jumps to the top, otherwise st > ld > if
                    if (bus.if_req && (promote || !(bus.st_req || bus.ld_req))) begin
                        bus.if_gnt = 1'b1;
                        rd_go      = 1'b1;
                        rd_addr    = bus.if_addr;
                    end else if (bus.st_req) begin
                        bus.st_gnt = 1'b1;
                    end else if (bus.ld_req) begin
                        bus.ld_gnt = 1'b1;
                        rd_go      = 1'b1;
                        rd_addr    = bus.ld_addr;
                    end

                    if (rd_go) begin
                        bus.mem_ren  = 1'b1;
                        bus.mem_addr = rd_addr[ADDR_W-1:1];
                        widx_d       = rd_addr[ADDR_W-1:1];
                        rd_ld_d      = bus.ld_gnt;
                        if (rd_addr[0]) begin
                            state_d = LD_HI;
                        end else begin
                            if_rv_d = bus.if_gnt;
                            ld_rv_d = bus.ld_gnt;
                        end
                    end

                    if (bus.st_gnt) begin
                        bus.mem_wen  = 1'b1;
                        bus.mem_addr = bus.st_addr[ADDR_W-1:1];
                        widx_d       = bus.st_addr[ADDR_W-1:1];
                        if (bus.st_addr[0]) begin
                            bus.mem_wbe   = 2'b10;
                            bus.mem_wdata = {bus.st_data[7:0], 8'h00};
                            byte_d        = bus.st_data[15:8];
                            state_d       = ST_HI;
                        end else begin
                            bus.mem_wbe   = 2'b11;
                            bus.mem_wdata = bus.st_data;
                            bus.st_done   = 1'b1;
                        end
                    end

                    if (bus.if_gnt) begin
                        starve_d = '0;
                    end else if (bus.if_req && (bus.st_gnt || bus.ld_gnt) && !promote) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end

                LD_HI: begin
                    // Word W arrives now; keep its high byte, fetch W+1 (wraps naturally)
                    bus.mem_ren  = 1'b1;
                    bus.mem_addr = widx_q + WORD_W'(1);
                    byte_d       = bus.mem_rdata[15:8];
                    mis_d        = 1'b1;
                    if_rv_d      = !rd_ld_q;
                    ld_rv_d      = rd_ld_q;
                    state_d      = IDLE;
                end

                ST_HI: begin
                    bus.mem_wen   = 1'b1;
                    bus.mem_addr  = widx_q + WORD_W'(1);
                    bus.mem_wbe   = 2'b01;
                    bus.mem_wdata = {8'h00, byte_q};
                    bus.st_done   = 1'b1;
                    state_d       = IDLE;
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
            widx_q   <= '0;
            byte_q   <= 8'h00;
            rd_ld_q  <= 1'b0;
            if_rv_q  <= 1'b0;
            ld_rv_q  <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            widx_q   <= widx_d;
            byte_q   <= byte_d;
            rd_ld_q  <= rd_ld_d;
            if_rv_q  <= if_rv_d;
            ld_rv_q  <= ld_rv_d;
            mis_q    <= mis_d;
        end
    end

    logic [15:0] rd_word;
    assign rd_word = mis_q ? {bus.mem_rdata[7:0], byte_q} : bus.mem_rdata;

    // Read data is only driven while the matching rvalid is high
    assign bus.if_rvalid = if_rv_q;
    assign bus.ld_rvalid = ld_rv_q;
    assign bus.if_rdata  = if_rv_q ? rd_word : 16'h0000;
    assign bus.ld_rdata  = ld_rv_q ? rd_word : 16'h0000;
endmodule
